core_avalon_master: RTL and testbench

- Bridges the arm810 core's simple word bus (addr/start/write/ready) to an Avalon-MM master port on the platform interconnect.
- Sits between the core and the platform fabric.
- Converts each single-cycle start into one Avalon read or write, including waitrequest and readdatavalid handling.
- Returns registered read data with a one-cycle ready pulse. A watchdog converts hung transactions into a fault response.

---
 rtl/core_avalon_master_if.sv | 41 ++++
 rtl/core_avalon_master.sv | 147 ++++++++++++++
 tb/tb_core_avalon_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/core_avalon_master_if.sv
// core_avalon_master_if
//   Bundles the core-side word bus and the Avalon-MM master signals of the
//   core_avalon_master bridge.
//   modport master : the bridge's view (drives core_data_rd/ready/fault and
//                    the avl_* request signals).
//   modport slave  : the environment's view (core request side and Avalon
//                    slave responses).
interface core_avalon_master_if;
  // core side
  logic [29:0] core_addr;
  logic [31:0] core_data_wr;
  logic        core_write;
  logic        core_start;
  logic [31:0] core_data_rd;
  logic        core_ready;
  logic        core_fault;
  // Avalon-MM side
  logic [31:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic [1:0]  avl_response;

  modport master (
    input  core_addr, core_data_wr, core_write, core_start,
    output core_data_rd, core_ready, core_fault,
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
  );

  modport slave (
    output core_addr, core_data_wr, core_write, core_start,
    input  core_data_rd, core_ready, core_fault,
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
  );
endinterface

// File: rtl/core_avalon_master.sv
// core_avalon_master
//   Bridges the core's single-cycle start/ready word bus to an Avalon-MM
//   master. Each start becomes exactly one Avalon read or write; completion
//   is signalled by a one-cycle core_ready with registered read data and a
//   fault flag. A watchdog aborts transactions stuck in REQ or RESP.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - core_avalon_master_if.master (core word bus + Avalon-MM master)
// Parameters:
//   TIMEOUT_CYCLES - cycles in REQ/RESP before abort; 0 disables watchdog
//   TIMEOUT_W      - watchdog counter width, must hold TIMEOUT_CYCLES
module core_avalon_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_W      = 11
) (
  input logic                  clk,
  input logic                  rst,
  core_avalon_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_t;

  localparam bit                   LP_WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] LP_WD_LAST =
    TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_stale;
  logic [31:0]          r_avl_address;
  logic                 r_avl_read;
  logic                 r_avl_write;
  logic [31:0]          r_avl_writedata;
  logic [31:0]          r_core_data_rd;
  logic                 r_core_ready;
  logic                 r_core_fault;

  logic                 w_wd_expired;
  logic                 w_rdv_live;

  // The counter holds the number of REQ/RESP cycles already elapsed, so the
  // TIMEOUT_CYCLES-th cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign w_wd_expired = LP_WD_EN && (r_wd >= LP_WD_LAST);
  // A readdatavalid belonging to an abandoned read is never delivered.
  assign w_rdv_live   = bus.avl_readdatavalid && !r_stale;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_wd            <= '0;
      r_stale         <= 1'b0;
      r_avl_address   <= '0;
      r_avl_read      <= 1'b0;
      r_avl_write     <= 1'b0;
      r_avl_writedata <= '0;
      r_core_data_rd  <= '0;
      r_core_ready    <= 1'b0;
      r_core_fault    <= 1'b0;
    end else begin
      r_core_ready <= 1'b0;

      // Stale discard runs in every state; a timeout in RESP below may
      // re-arm the flag in the same cycle for the read just abandoned.
      if (bus.avl_readdatavalid && r_stale) begin
        r_stale <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.core_start) begin
            r_avl_address   <= {bus.core_addr, 2'b00};
            r_avl_writedata <= bus.core_data_wr;
            r_avl_write     <= bus.core_write;
            r_avl_read      <= !bus.core_write;
            r_wd            <= '0;
            r_state         <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (LP_WD_EN) begin
            r_wd <= r_wd + 1'b1;
          end
          if (!bus.avl_waitrequest) begin
            r_avl_read  <= 1'b0;
            r_avl_write <= 1'b0;
            if (r_avl_write) begin
              r_core_fault <= 1'b0;
              r_core_ready <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_state <= ST_RESP;
            end
          end else if (w_wd_expired) begin
            r_avl_read     <= 1'b0;
            r_avl_write    <= 1'b0;
            r_core_data_rd <= '1;
            r_core_fault   <= 1'b1;
            r_core_ready   <= 1'b1;
            r_state        <= ST_DONE;
          end
        end

        ST_RESP: begin
          if (LP_WD_EN) begin
            r_wd <= r_wd + 1'b1;
          end
          if (w_rdv_live) begin
            r_core_data_rd <= bus.avl_readdata;
            r_core_fault   <= (bus.avl_response != 2'b00);
            r_core_ready   <= 1'b1;
            r_state        <= ST_DONE;
          end else if (w_wd_expired) begin
            r_core_data_rd <= '1;
            r_core_fault   <= 1'b1;
            r_core_ready   <= 1'b1;
            r_stale        <= 1'b1;
            r_state        <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_core_fault <= 1'b0;
          r_state      <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.avl_address    = r_avl_address;
  assign bus.avl_read       = r_avl_read;
  assign bus.avl_write      = r_avl_write;
  assign bus.avl_writedata  = r_avl_writedata;
  assign bus.avl_byteenable = '1;
  assign bus.core_data_rd   = r_core_data_rd;
  assign bus.core_ready     = r_core_ready;
  assign bus.core_fault     = r_core_fault;

endmodule

// File: tb/tb_core_avalon_master.sv
module tb_core_avalon_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_avalon_master_if bus();

  core_avalon_master #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_W     (11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Inputs applied before a rising edge; expected outputs after that edge.
  typedef struct {
    logic        start;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        wt;
    logic        rdv;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic        e_rdy;
    logic        e_flt;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic start, input logic wr, input logic [29:0] addr,
    input logic [31:0] wdata, input logic wt, input logic rdv,
    input logic [31:0] rdata, input logic [1:0] resp,
    input logic e_rd, input logic e_wr, input logic [31:0] e_addr,
    input logic e_rdy, input logic e_flt, input logic [31:0] e_data);
    vec_t v;
    v.start = start; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.wt = wt; v.rdv = rdv; v.rdata = rdata; v.resp = resp;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_rdy = e_rdy; v.e_flt = e_flt; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic start, input logic wr, input logic [29:0] addr,
                        input logic [31:0] wdata, input logic wt, input logic rdv,
                        input logic [31:0] rdata, input logic [1:0] resp);
    bus.core_start        = start;
    bus.core_write        = wr;
    bus.core_addr         = addr;
    bus.core_data_wr      = wdata;
    bus.avl_waitrequest   = wt;
    bus.avl_readdatavalid = rdv;
    bus.avl_readdata      = rdata;
    bus.avl_response      = resp;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] last_wdata;
    last_wdata = '0;

    vecs[0]  = mk(1,1,30'h10,32'hDEADBEEF,0,0,0,0,   0,1,32'h40,0,0,32'h0);
    vecs[1]  = mk(0,0,0,0,0,0,0,0,                   0,0,0,1,0,32'h0);
    vecs[2]  = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h0);
    vecs[3]  = mk(1,0,30'h3,0,0,0,0,0,               1,0,32'hC,0,0,32'h0);
    vecs[4]  = mk(0,0,0,0,1,0,0,0,                   1,0,32'hC,0,0,32'h0);
    vecs[5]  = mk(0,0,0,0,1,0,0,0,                   1,0,32'hC,0,0,32'h0);
    vecs[6]  = mk(0,0,0,0,1,0,0,0,                   1,0,32'hC,0,0,32'h0);
    vecs[7]  = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h0);
    vecs[8]  = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h0);
    vecs[9]  = mk(0,0,0,0,0,1,32'h12345678,0,        0,0,0,1,0,32'h12345678);
    vecs[10] = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h12345678);
    vecs[11] = mk(1,0,30'h5,0,0,0,0,0,               1,0,32'h14,0,0,32'h12345678);
    vecs[12] = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h12345678);
    vecs[13] = mk(0,0,0,0,0,1,32'hCAFE0001,2'b10,    0,0,0,1,1,32'hCAFE0001);
    vecs[14] = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'hCAFE0001);
    vecs[15] = mk(1,1,30'h20,32'h11112222,0,0,0,0,   0,1,32'h80,0,0,32'hCAFE0001);
    vecs[16] = mk(1,0,30'h7,0,1,0,0,0,               0,1,32'h80,0,0,32'hCAFE0001);
    vecs[17] = mk(0,0,0,0,0,0,0,0,                   0,0,0,1,0,32'hCAFE0001);
    vecs[18] = mk(1,0,30'h7,0,0,0,0,0,               0,0,0,0,0,32'hCAFE0001);
    vecs[19] = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'hCAFE0001);
    vecs[20] = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'hCAFE0001);
    vecs[21] = mk(1,0,30'h1,0,0,0,0,0,               1,0,32'h4,0,0,32'hCAFE0001);
    vecs[22] = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'hCAFE0001);
    vecs[23] = mk(0,0,0,0,0,1,32'h0BADF00D,0,        0,0,0,1,0,32'h0BADF00D);
    vecs[24] = mk(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h0BADF00D);

    // reset state
    rst = 1'b1;
    set_in(0,0,0,0,0,0,0,0);
    @(negedge clk);
    chk("rst_read",  {31'b0, bus.avl_read},  32'd0);
    chk("rst_write", {31'b0, bus.avl_write}, 32'd0);
    chk("rst_ready", {31'b0, bus.core_ready}, 32'd0);
    chk("rst_fault", {31'b0, bus.core_fault}, 32'd0);
    chk("rst_data",  bus.core_data_rd, 32'd0);
    chk("rst_addr",  bus.avl_address, 32'd0);
    chk("rst_be",    {28'b0, bus.avl_byteenable}, 32'hF);
    rst = 1'b0;

    // table-driven sequences
    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].start, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].wt, vecs[i].rdv, vecs[i].rdata, vecs[i].resp);
      if (vecs[i].start && vecs[i].wr) last_wdata = vecs[i].wdata;
      step();
      chk($sformatf("v%0d_read", i),  {31'b0, bus.avl_read},   {31'b0, vecs[i].e_rd});
      chk($sformatf("v%0d_write", i), {31'b0, bus.avl_write},  {31'b0, vecs[i].e_wr});
      chk($sformatf("v%0d_ready", i), {31'b0, bus.core_ready}, {31'b0, vecs[i].e_rdy});
      chk($sformatf("v%0d_fault", i), {31'b0, bus.core_fault}, {31'b0, vecs[i].e_flt});
      chk($sformatf("v%0d_data", i),  bus.core_data_rd, vecs[i].e_data);
      if (vecs[i].e_rd || vecs[i].e_wr)
        chk($sformatf("v%0d_addr", i), bus.avl_address, vecs[i].e_addr);
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d_wdata", i), bus.avl_writedata, last_wdata);
        chk($sformatf("v%0d_be", i), {28'b0, bus.avl_byteenable}, 32'hF);
      end
    end

    // watchdog timeout in RESP, then a new read whose RESP sees the late
    // (stale) readdatavalid first and its own data second
    set_in(1,0,30'h9,0,0,0,0,0);
    step();                                       // cycle 1: REQ
    chk("to_read_issued", {31'b0, bus.avl_read}, 32'd1);
    set_in(0,0,0,0,0,0,0,0);
    for (int k = 2; k <= 8; k++) begin
      step();
      chk($sformatf("to_noready_c%0d", k), {31'b0, bus.core_ready}, 32'd0);
    end
    step();                                       // cycle 9: DONE
    chk("to_ready", {31'b0, bus.core_ready}, 32'd1);
    chk("to_fault", {31'b0, bus.core_fault}, 32'd1);
    chk("to_data",  bus.core_data_rd, 32'hFFFFFFFF);
    chk("to_read_dropped", {31'b0, bus.avl_read}, 32'd0);
    set_in(1,0,30'hA,0,0,0,0,0);                  // start in DONE: ignored
    step();                                       // IDLE
    chk("to_done_start_ignored", {31'b0, bus.avl_read}, 32'd0);
    chk("to_ready_cleared", {31'b0, bus.core_ready}, 32'd0);
    step();                                       // start taken in IDLE -> REQ
    chk("st_read_issued", {31'b0, bus.avl_read}, 32'd1);
    chk("st_addr", bus.avl_address, 32'h28);
    set_in(0,0,0,0,0,0,0,0);
    step();                                       // RESP
    set_in(0,0,0,0,0,1,32'h0000AAAA,0);           // late, stale data
    step();
    chk("st_stale_noready", {31'b0, bus.core_ready}, 32'd0);
    chk("st_stale_data", bus.core_data_rd, 32'hFFFFFFFF);
    set_in(0,0,0,0,0,1,32'h00005555,0);
    step();
    chk("st_ready", {31'b0, bus.core_ready}, 32'd1);
    chk("st_data",  bus.core_data_rd, 32'h00005555);
    chk("st_fault", {31'b0, bus.core_fault}, 32'd0);
    set_in(0,0,0,0,0,0,0,0);
    step();

    // asynchronous reset mid-REQ, then a fresh write
    set_in(1,0,30'h11,0,1,0,0,0);
    step();
    set_in(0,0,0,0,1,0,0,0);
    step();
    chk("ar_read_held", {31'b0, bus.avl_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_read_drop",  {31'b0, bus.avl_read}, 32'd0);
    chk("ar_ready",      {31'b0, bus.core_ready}, 32'd0);
    chk("ar_addr",       bus.avl_address, 32'd0);
    set_in(0,0,0,0,0,0,0,0);
    step();
    rst = 1'b0;
    set_in(1,1,30'h30,32'h00005A5A,0,0,0,0);
    step();
    chk("ar_wr_issued", {31'b0, bus.avl_write}, 32'd1);
    chk("ar_wr_addr",   bus.avl_address, 32'hC0);
    chk("ar_wr_data",   bus.avl_writedata, 32'h00005A5A);
    set_in(0,0,0,0,0,0,0,0);
    step();
    chk("ar_wr_ready", {31'b0, bus.core_ready}, 32'd1);
    chk("ar_wr_fault", {31'b0, bus.core_fault}, 32'd0);
    chk("ar_wr_drop",  {31'b0, bus.avl_write}, 32'd0);
    step();
    chk("ar_wr_ready_pulse", {31'b0, bus.core_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
